// File: rtl/ct_ifu_spsram_128x16_ctrl.sv
// Access scheduler for one 128x16 single-port bit-write SRAM (active-low CEN/GWEN/WEN).
// The array is cleared after reset and on invalidate, then one writer and one reader share the port.
//   state | meaning
//   IDLE  | arbitrate writer/reader, or launch a clear if one is pending or requested
//   INIT  | write INIT_VAL to address cnt, one entry per cycle, 0..127
`timescale 1ns/1ps
module ct_ifu_spsram_128x16_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 7,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int unsigned           STARVE_MAX = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_req,
    output logic                  inv_busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_e;

    localparam logic [1:0] SCNT_MAX = 2'(STARVE_MAX);

    state_e                state_q, state_d;
    logic                  init_pend_q, init_pend_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            scnt_q, scnt_d;
    logic                  rd_vld_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= IDLE;
            init_pend_q <= 1'b1;
            cnt_q       <= '0;
            scnt_q      <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pend_q <= init_pend_d;
            cnt_q       <= cnt_d;
            scnt_q      <= scnt_d;
            rd_vld_q    <= rd_gnt;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_pend_d = init_pend_q;
        cnt_d       = cnt_q;
        scnt_d      = scnt_q;
        wr_gnt      = 1'b0;
        rd_gnt      = 1'b0;
        sram_a      = '0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_d      = '0;
        inv_busy    = init_pend_q | (state_q == INIT) | inv_req;

        case (state_q)
            INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt_q;
                sram_d    = INIT_VAL;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (init_pend_q || inv_req) begin
                    state_d     = INIT;
                    cnt_d       = '0;
                    init_pend_d = 1'b0;
                end else if (wr_req && !(rd_req && scnt_q == SCNT_MAX)) begin
                    wr_gnt    = 1'b1;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
                    sram_wen  = ~wr_mask;
                end else if (rd_req) begin
                    rd_gnt   = 1'b1;
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
            end
        endcase

        // A read that keeps losing to writes counts up until it is forced through.
        if (rd_gnt || !rd_req) begin
            scnt_d = '0;
        end else if (wr_gnt) begin
            scnt_d = scnt_q + 2'd1;
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = sram_q;

endmodule

// File: tb/tb_ct_ifu_spsram_128x16_ctrl.sv
// Randomized bench for ct_ifu_spsram_128x16_ctrl: a bench-side SRAM plus a spec-level
// reference model checked on every falling edge, with directed scenarios pinning literal values.
`timescale 1ns/1ps
module tb_ct_ifu_spsram_128x16_ctrl;

    localparam logic [15:0] INIT_VAL = 16'h0000;
    localparam int          SMAX     = 3;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        inv_req;
    logic        inv_busy;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] wr_mask;
    logic        wr_gnt;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic        rd_gnt;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic [6:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [15:0] sram_wen;
    logic [15:0] sram_d;
    logic [15:0] sram_q;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ct_ifu_spsram_128x16_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .inv_req        (inv_req),
        .inv_busy       (inv_busy),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // SRAM macro: starts full of garbage so the clear has something to erase.
    logic [15:0] sram_mem [128];
    initial begin
        sram_q = '0;
        for (int i = 0; i < 128; i++) sram_mem[i] = 16'($urandom);
        forever begin
            @(posedge clk);
            if (sram_cen === 1'b0) begin
                if (sram_gwen === 1'b0)
                    sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
                else
                    sram_q <= sram_mem[sram_a];
            end
        end
    end

    // Reference model: clr_pos = next entry to clear (-1 when not clearing), loss = reads lost in a row.
    logic [15:0] ref_mem [128];
    int          pend, clr_pos, loss;
    bit          vld_e;
    logic [15:0] rdat_e;
    bit          m_busy, m_wg, m_rg, m_cen, m_gwen;
    logic [15:0] m_wen, m_d;
    logic [6:0]  m_a;

    always @(negedge clk) begin
        if (cpurst_b !== 1'b1) begin
            pend = 1; clr_pos = -1; loss = 0; vld_e = 0;
            chk("rst_inv_busy", inv_busy, 1);
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_rd_vld", rd_vld, 0);
            chk("rst_cen", sram_cen, 1);
            chk("rst_gwen", sram_gwen, 1);
            chk("rst_wen", sram_wen, 16'hFFFF);
        end else begin
            chk("rd_vld", rd_vld, vld_e);
            if (vld_e) chk("rd_data", rd_data, rdat_e);
            m_busy = (pend != 0) || (clr_pos >= 0) || inv_req;
            m_wg = 0; m_rg = 0;
            m_cen = 1; m_gwen = 1; m_wen = 16'hFFFF; m_a = '0; m_d = '0;
            if (clr_pos >= 0) begin
                m_cen = 0; m_gwen = 0; m_wen = '0; m_a = 7'(clr_pos); m_d = INIT_VAL;
            end else if (!m_busy) begin
                m_wg = wr_req && !(rd_req && loss == SMAX);
                m_rg = rd_req && !m_wg;
                if (m_wg) begin
                    m_cen = 0; m_gwen = 0; m_a = wr_addr; m_d = wr_data; m_wen = ~wr_mask;
                end else if (m_rg) begin
                    m_cen = 0; m_a = rd_addr;
                end
            end
            chk("inv_busy", inv_busy, m_busy);
            chk("wr_gnt", wr_gnt, m_wg);
            chk("rd_gnt", rd_gnt, m_rg);
            chk("sram_cen", sram_cen, m_cen);
            chk("sram_gwen", sram_gwen, m_gwen);
            chk("sram_wen", sram_wen, m_wen);
            chk("sram_a", sram_a, m_a);
            chk("sram_d", sram_d, m_d);

            vld_e = m_rg;
            if (m_rg) rdat_e = ref_mem[rd_addr];
            if (clr_pos >= 0) begin
                ref_mem[clr_pos] = INIT_VAL;
                clr_pos = (clr_pos == 127) ? -1 : clr_pos + 1;
            end else if (pend != 0 || inv_req) begin
                pend = 0; clr_pos = 0;
            end else if (m_wg) begin
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
            end
            if (m_rg || !rd_req) loss = 0;
            else if (m_wg) loss++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        inv_req = 0; wr_req = 0; rd_req = 0;
    endtask

    // Counts busy cycles and clear writes from the next falling edge until inv_busy drops.
    task automatic busy_scan(output int nb, output int nw, output int first_a);
        nb = 0; nw = 0; first_a = -1;
        @(negedge clk);
        while (inv_busy === 1'b1 && nb < 300) begin
            nb++;
            if (sram_cen === 1'b0 && sram_gwen === 1'b0) begin
                if (first_a < 0) first_a = int'(sram_a);
                nw++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (inv_busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < 400), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nw, fa, nz, nv;
        bit hold_w, hold_r;
        logic [7:0] pat;

        cpurst_b = 0; clear_reqs();
        wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
        repeat (3) cyc();
        cpurst_b = 1;

        busy_scan(nb, nw, fa);
        chk("boot_busy_cycles", nb, 129);
        chk("boot_clear_writes", nw, 128);
        chk("boot_first_addr", fa, 0);

        cyc(); rd_req = 1; rd_addr = 7'd5;
        @(negedge clk); chk("rd5_gnt", rd_gnt, 1);
        cyc(); rd_req = 0;
        @(negedge clk); chk("rd5_vld", rd_vld, 1); chk("rd5_data", rd_data, 16'h0000);

        cyc(); wr_req = 1; wr_addr = 7'd7; wr_data = 16'hA5A5; wr_mask = 16'hFFFF;
        cyc(); wr_data = 16'hFFFF; wr_mask = 16'h00F0;
        cyc(); wr_req = 0; rd_req = 1; rd_addr = 7'd7;
        @(negedge clk); chk("rd7_gnt", rd_gnt, 1);
        cyc(); rd_req = 0;
        @(negedge clk); chk("rd7_vld", rd_vld, 1); chk("rd7_data", rd_data, 16'hA5F5);

        cyc(); wr_req = 1; rd_req = 1; wr_addr = 7'd3; rd_addr = 7'd3;
        wr_data = 16'h1234; wr_mask = 16'hFFFF;
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat = {pat[6:0], rd_gnt};
            cyc();
        end
        clear_reqs();
        chk("starve_pattern", pat, 8'b0001_0001);

        hold_w = 0; hold_r = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (!hold_w) begin
                wr_req  = ($urandom_range(0, 2) != 0);
                wr_addr = 7'($urandom_range(0, 15));
                wr_data = 16'($urandom);
                wr_mask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            end
            if (!hold_r) begin
                rd_req  = ($urandom_range(0, 1) != 0);
                rd_addr = 7'($urandom_range(0, 15));
            end
            inv_req = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            hold_w = wr_req && !wr_gnt;
            hold_r = rd_req && !rd_gnt;
        end
        cyc(); clear_reqs();

        wait_idle("idle_before_inv");
        cyc(); wr_req = 1; wr_addr = 7'd9; wr_data = 16'hBEEF; wr_mask = 16'hFFFF;
        cyc(); wr_req = 1; rd_req = 1; inv_req = 1; wr_addr = 7'd10; rd_addr = 7'd9;
        @(negedge clk);
        chk("inv_same_wr_gnt", wr_gnt, 0);
        chk("inv_same_rd_gnt", rd_gnt, 0);
        cyc(); clear_reqs();
        busy_scan(nb, nw, fa);
        chk("inv_busy_cycles", nb, 128);
        chk("inv_clear_writes", nw, 128);
        nz = 0; nv = 0;
        for (int a = 0; a < 128; a++) begin
            cyc(); rd_req = 1; rd_addr = 7'(a);
            @(negedge clk);
            if (rd_vld === 1'b1) begin nv++; if (rd_data !== 16'h0000) nz++; end
        end
        cyc(); rd_req = 0;
        @(negedge clk);
        if (rd_vld === 1'b1) begin nv++; if (rd_data !== 16'h0000) nz++; end
        chk("inv_read_vld_count", nv, 128);
        chk("inv_read_nonzero", nz, 0);

        cyc(); inv_req = 1;
        cyc(); inv_req = 0;
        for (int k = 0; k < 60; k++) cyc();
        @(negedge clk); chk("pre_rst_clear_addr", sram_a, 7'd60);
        cyc(); cpurst_b = 0;
        @(negedge clk);
        chk("midrst_busy", inv_busy, 1);
        chk("midrst_cen", sram_cen, 1);
        chk("midrst_a", sram_a, 7'd0);
        cyc(); cyc(); cpurst_b = 1;
        busy_scan(nb, nw, fa);
        chk("rerun_busy_cycles", nb, 129);
        chk("rerun_clear_writes", nw, 128);
        chk("rerun_first_addr", fa, 0);

        cyc(); inv_req = 1;
        cyc(); inv_req = 0;
        nb = 0;
        @(negedge clk);
        while (inv_busy === 1'b1 && nb < 300) begin
            nb++;
            hold_w = (sram_a == 7'd99);
            cyc();
            inv_req = hold_w;
            @(negedge clk);
        end
        chk("inv_ignored_busy_cycles", nb, 128);
        cyc(); inv_req = 0; rd_req = 1; rd_addr = 7'd7;
        @(negedge clk); chk("post_inv_rd_gnt", rd_gnt, 1);
        cyc(); rd_req = 0;
        @(negedge clk); chk("post_inv_rd_data", rd_data, 16'h0000);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ct_ifu_spsram_128x16_ctrl.md
Name: ct_ifu_spsram_128x16_ctrl

Overview:
Access scheduler for one 128x16 single-port SRAM macro. Active-low CEN/GWEN/WEN bit-write SRAM interface.
- Clears the whole array automatically after reset and again on an invalidate request.
- Shares the single port between one write requester and one read requester, with write priority and a read anti-starvation guard.
- Returns read data with a 1-cycle valid strobe.
- Sits in the IFU between the lookup/update pipeline and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 7, SRAM address width (depth 2^ADDR_WIDTH = 128)
DATA_WIDTH, 16, SRAM data width; equals the bit-write mask width
INIT_VAL, 16'h0000, value written to every entry during init/invalidate
STARVE_MAX, 3, consecutive read losses before the read is forced to win

Ports:
forever_cpuclk  in  1  clock; all flops rising-edge
cpurst_b  in  1  asynchronous active-low reset
inv_req  in  1  invalidate request; single-cycle pulse or level
inv_busy  out  1  high while init is pending or clearing; no grants while high
wr_req  in  1  write request
wr_addr  in  7  write address
wr_data  in  16  write data
wr_mask  in  16  active-high per-bit write enable
wr_gnt  out  1  write accepted this cycle (combinational)
rd_req  in  1  read request
rd_addr  in  7  read address
rd_gnt  out  1  read accepted this cycle (combinational)
rd_vld  out  1  rd_data valid; asserted the cycle after rd_gnt
rd_data  out  16  read data; equals sram_q, meaningful only when rd_vld=1
sram_a  out  7  SRAM address
sram_cen  out  1  SRAM chip enable, active-low
sram_gwen  out  1  SRAM global write enable, active-low
sram_wen  out  16  SRAM bit write enable, active-low
sram_d  out  16  SRAM write data
sram_q  in  16  SRAM read data, valid the cycle after the access

Behaviour:
- States are IDLE and INIT, plus init_pend flag, 7-bit clear counter cnt and starvation counter scnt (2 bits).
- Async reset values: state=IDLE, init_pend=1, cnt=0, scnt=0, rd_vld=0.
  - Combinational outputs during reset: inv_busy=1, wr_gnt=0, rd_gnt=0, sram_cen=1, sram_gwen=1, sram_wen=16'hFFFF.
- IDLE with init_pend=1: no grants, SRAM idle. Next edge: state=INIT, cnt=0, init_pend=0.
- IDLE with inv_req=1: same as init_pend. No grants this cycle; INIT next cycle. inv_req has priority over any wr_req/rd_req in the same cycle.
- INIT write behaviour, one write per cycle:
  - sram_cen=0, sram_gwen=0, sram_wen=16'h0000, sram_a=cnt, sram_d=INIT_VAL.
  - cnt increments; after the cnt=127 write, state=IDLE.
  - Duration is exactly 128 cycles. inv_busy=1 for all of them. wr_gnt=rd_gnt=0.
- inv_req during INIT is ignored (the clear in progress already covers it). cnt does not restart.
- Reset asserted mid-INIT aborts the clear. After release the full 128-entry clear reruns from address 0.
- IDLE arbitration, with inv_busy=0 and no inv_req:
  - Only wr_req: wr_gnt=1.
  - Only rd_req: rd_gnt=1.
  - Both, scnt<STARVE_MAX: wr_gnt=1, scnt+1.
  - Both, scnt==STARVE_MAX: rd_gnt=1, wr_gnt=0.
  - scnt clears to 0 whenever rd_gnt=1 or rd_req=0. At most one grant per cycle.
- Write access: sram_cen=0, sram_gwen=0, sram_a=wr_addr, sram_d=wr_data, sram_wen=~wr_mask.
  - wr_mask=0 is still granted and consumes the cycle; no bit changes.
- Read access: sram_cen=0, sram_gwen=1, sram_wen=16'hFFFF, sram_a=rd_addr. sram_d is don't-care; drive 0.
- rd_vld is rd_gnt registered. rd_data=sram_q.
  - Back-to-back reads give rd_vld high on consecutive cycles.
  - A write the cycle after a read does not corrupt rd_data.
- No access: sram_cen=1, sram_gwen=1, sram_wen=16'hFFFF, sram_a=0, sram_d=0.
- A requester that is not granted must hold its request. The block keeps no request queue.

Test Plan:
- Reset release -> inv_busy=1 for 129 cycles (1 pending + 128 clear). sram_a steps 0..127 with gwen=0 and wen=0. Then reading address 5 returns 16'h0000 with rd_vld one cycle after rd_gnt.
- Write addr 7 data 16'hA5A5 mask 16'hFFFF, then write addr 7 data 16'hFFFF mask 16'h00F0, then read addr 7 -> rd_data=16'hA5F5.
- rd_req and wr_req both held high for 8 cycles -> grant pattern W,W,W,R,W,W,W,R. rd_vld is high the cycle after each R.
- inv_req in the same cycle as wr_req and rd_req -> no grant that cycle, INIT for the next 128 cycles, prior data at all addresses reads back 16'h0000.
- cpurst_b pulsed low at clear cycle 60 -> all outputs return to reset values immediately. After release the clear restarts at sram_a=0 and completes 128 writes.
- inv_req pulsed again at clear cycle 100 -> ignored, INIT ends at cnt=127 with no restart, inv_busy falls on schedule.
